arrhythmia_window_ctrl: RTL and testbench

Streaming front-end and result back-end for the `top_arrhythmia` classifier core. It deserializes a stream of Q4.11 sign-magnitude ECG samples into the 10-sample window bus `x`, and sequences the core's reset/run cycle. When the core raises `done_flag_out`, it compares `y1` against `y2` and presents a one-bit class decision on a valid/ready result port. It replaces the hand-driven reset/load/compare sequence the bench used, so the core can run back-to-back windows in-system.

---
 rtl/arrhythmia_pkg.sv | 39 +++
 rtl/sm_compare.sv | 58 +++++
 rtl/arrhythmia_window_ctrl.sv | 123 ++++++++++++
 tb/tb_arrhythmia_window_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arrhythmia_pkg.sv
// rtl/arrhythmia_pkg.sv - shared types, defaults and compare helper for the arrhythmia window controller
//
// Purpose : state encoding, default widths and the sign-magnitude compare
//           used by both the RTL and any bench that needs a reference.
// Contents: DEF_BITSIZE, DEF_N_SAMPLES, win_state_t, sm_greater().
package arrhythmia_pkg;

  localparam int DEF_BITSIZE   = 16;
  localparam int DEF_N_SAMPLES = 10;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESULT = 2'd3
  } win_state_t;

  // a > b for sign-magnitude values. +0 vs -0 returns 1 because the sign
  // test runs before any magnitude test, matching compare_sign_mag.
  function automatic logic sm_greater(input logic [DEF_BITSIZE-1:0] a,
                                      input logic [DEF_BITSIZE-1:0] b);
    logic                   sa;
    logic                   sb;
    logic [DEF_BITSIZE-2:0] ma;
    logic [DEF_BITSIZE-2:0] mb;
    sa = a[DEF_BITSIZE-1];
    sb = b[DEF_BITSIZE-1];
    ma = a[DEF_BITSIZE-2:0];
    mb = b[DEF_BITSIZE-2:0];
    if (sa != sb) begin
      return !sa;
    end else if (!sa) begin
      return ma > mb;
    end else begin
      return ma < mb;
    end
  endfunction

endpackage

// File: rtl/sm_compare.sv
// rtl/sm_compare.sv - registered sign-magnitude comparator and score capture
//
// Purpose : captures y1/y2 and the class decision in one cycle when the
//           controller leaves RUN; holds them until the next capture.
// Ports   : i_clk, i_reset (sync, active-high)
//           i_capture      - load the result registers this cycle
//           i_timeout      - capture is a timeout: class/scores forced to 0
//           i_y1, i_y2     - core scores
//           o_class, o_score1, o_score2, o_timeout - registered result
module sm_compare
  import arrhythmia_pkg::*;
#(
  parameter int BITSIZE = DEF_BITSIZE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_capture,
  input  logic               i_timeout,
  input  logic [BITSIZE-1:0] i_y1,
  input  logic [BITSIZE-1:0] i_y2,
  output logic               o_class,
  output logic [BITSIZE-1:0] o_score1,
  output logic [BITSIZE-1:0] o_score2,
  output logic               o_timeout
);

  logic               r_class;
  logic [BITSIZE-1:0] r_score1;
  logic [BITSIZE-1:0] r_score2;
  logic               r_timeout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_class   <= 1'b0;
      r_score1  <= '0;
      r_score2  <= '0;
      r_timeout <= 1'b0;
    end else if (i_capture) begin
      if (i_timeout) begin
        r_class   <= 1'b0;
        r_score1  <= '0;
        r_score2  <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_class   <= sm_greater(i_y1, i_y2);
        r_score1  <= i_y1;
        r_score2  <= i_y2;
        r_timeout <= 1'b0;
      end
    end
  end

  assign o_class   = r_class;
  assign o_score1  = r_score1;
  assign o_score2  = r_score2;
  assign o_timeout = r_timeout;

endmodule

// File: rtl/arrhythmia_window_ctrl.sv
// rtl/arrhythmia_window_ctrl.sv - sample window packer and run/result sequencer for top_arrhythmia
//
// Purpose : packs N_SAMPLES incoming samples into the core's x bus, pulses
//           the core reset, waits for done (or timeout) and offers the
//           class decision on a valid/ready port.
// Ports   : i_clk, i_reset (sync, active-high)
//           i_sample_in/i_sample_valid/o_sample_ready - sample stream in
//           o_core_reset, o_core_x                    - core drive
//           i_core_y1, i_core_y2, i_core_done         - core results
//           o_class_out, o_score1_out, o_score2_out,
//           o_timeout_out, o_class_valid/i_class_ready - result port
module arrhythmia_window_ctrl
  import arrhythmia_pkg::*;
#(
  parameter int BITSIZE        = DEF_BITSIZE,
  parameter int N_SAMPLES      = DEF_N_SAMPLES,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [BITSIZE-1:0]           i_sample_in,
  input  logic                         i_sample_valid,
  output logic                         o_sample_ready,
  output logic                         o_core_reset,
  output logic [BITSIZE*N_SAMPLES-1:0] o_core_x,
  input  logic [BITSIZE-1:0]           i_core_y1,
  input  logic [BITSIZE-1:0]           i_core_y2,
  input  logic                         i_core_done,
  output logic                         o_class_out,
  output logic [BITSIZE-1:0]           o_score1_out,
  output logic [BITSIZE-1:0]           o_score2_out,
  output logic                         o_timeout_out,
  output logic                         o_class_valid,
  input  logic                         i_class_ready
);

  localparam int LW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  win_state_t                   r_state;
  win_state_t                   w_next_state;
  logic [3:0]                   r_fill_cnt;
  logic [LW-1:0]                r_launch_cnt;
  logic [TW-1:0]                r_tmo_cnt;
  logic [BITSIZE*N_SAMPLES-1:0] r_core_x;
  logic                         r_core_reset;
  logic                         r_class_valid;

  logic w_accept;
  logic w_last_sample;
  logic w_launch_done;
  logic w_tmo_hit;
  logic w_capture;

  assign w_accept      = i_sample_valid && (r_state == S_FILL);
  assign w_last_sample = (r_fill_cnt == 4'(N_SAMPLES - 1));
  assign w_launch_done = (r_launch_cnt == LW'(RST_CYCLES - 1));
  assign w_tmo_hit     = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // core_done is only looked at in RUN; it also takes priority over timeout
  assign w_capture     = (r_state == S_RUN) && (i_core_done || w_tmo_hit);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:   if (w_accept && w_last_sample) w_next_state = S_LAUNCH;
      S_LAUNCH: if (w_launch_done)             w_next_state = S_RUN;
      S_RUN:    if (w_capture)                 w_next_state = S_RESULT;
      S_RESULT: if (i_class_ready)             w_next_state = S_FILL;
      default:                                 w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_FILL;
      r_fill_cnt    <= '0;
      r_launch_cnt  <= '0;
      r_tmo_cnt     <= '0;
      r_core_x      <= '0;
      r_core_reset  <= 1'b1;
      r_class_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // x is only written in FILL, so it stays frozen through LAUNCH..RESULT
      if (w_accept) begin
        for (int k = 0; k < N_SAMPLES; k++) begin
          if (r_fill_cnt == 4'(k)) begin
            r_core_x[BITSIZE*(N_SAMPLES-k)-1 -: BITSIZE] <= i_sample_in;
          end
        end
        r_fill_cnt <= w_last_sample ? 4'd0 : r_fill_cnt + 4'd1;
      end

      r_launch_cnt  <= (r_state == S_LAUNCH) ? r_launch_cnt + LW'(1) : '0;
      r_tmo_cnt     <= (r_state == S_RUN)    ? r_tmo_cnt + TW'(1)    : '0;
      r_core_reset  <= (w_next_state != S_RUN);
      r_class_valid <= (w_next_state == S_RESULT);
    end
  end

  sm_compare #(
    .BITSIZE (BITSIZE)
  ) u_cmp (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_capture (w_capture),
    .i_timeout (!i_core_done),
    .i_y1      (i_core_y1),
    .i_y2      (i_core_y2),
    .o_class   (o_class_out),
    .o_score1  (o_score1_out),
    .o_score2  (o_score2_out),
    .o_timeout (o_timeout_out)
  );

  assign o_sample_ready = (r_state == S_FILL);
  assign o_core_reset   = r_core_reset;
  assign o_core_x       = r_core_x;
  assign o_class_valid  = r_class_valid;

endmodule

// File: tb/tb_arrhythmia_window_ctrl.sv
// tb/tb_arrhythmia_window_ctrl.sv - scoreboard bench for arrhythmia_window_ctrl
module tb_arrhythmia_window_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         core_reset;
  logic [159:0] core_x;
  logic [15:0]  core_y1 = '0;
  logic [15:0]  core_y2 = '0;
  logic         core_done = 1'b0;
  logic         class_out;
  logic [15:0]  score1_out;
  logic [15:0]  score2_out;
  logic         timeout_out;
  logic         class_valid;
  logic         class_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [33:0] sb[$];

  localparam logic [159:0] V1 = 160'h0471_03B4_82A0_0125_8F00_0000_7FFF_8001_0ABC_036B;
  localparam logic [159:0] V2 = 160'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA;
  localparam logic [159:0] V3 = 160'hF00D_0001_0002_0003_0004_0005_0006_0007_0008_BEEF;
  localparam logic [159:0] V4 = 160'h0A01_0A02_0A03_0A04_0A05_0A06_0A07_0A08_0A09_0A0A;

  arrhythmia_window_ctrl dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_sample_in    (sample_in),
    .i_sample_valid (sample_valid),
    .o_sample_ready (sample_ready),
    .o_core_reset   (core_reset),
    .o_core_x       (core_x),
    .i_core_y1      (core_y1),
    .i_core_y2      (core_y2),
    .i_core_done    (core_done),
    .o_class_out    (class_out),
    .o_score1_out   (score1_out),
    .o_score2_out   (score2_out),
    .o_timeout_out  (timeout_out),
    .o_class_valid  (class_valid),
    .i_class_ready  (class_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops the expected result whenever the result port handshakes
  always @(negedge clk) begin
    if (!reset && class_valid && class_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %0h required none",
                 {class_out, score1_out, score2_out, timeout_out});
      end else begin
        check("result", {class_out, score1_out, score2_out, timeout_out}, sb.pop_front());
      end
      n_popped++;
    end
  end

  task automatic send_window(input logic [159:0] vec, input int gap, input int n);
    for (int i = 0; i < n; i++) begin
      sample_in    = vec[159-16*i -: 16];
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      sample_in    = 16'hDEAD;
      if (i < n - 1) repeat (gap) tick();
    end
  endtask

  // called right after the last-sample acceptance edge
  task automatic check_launch(input logic [159:0] vec);
    check("core_x_packed", core_x, vec);
    check("ready_low_launch", sample_ready, 1'b0);
    check("core_reset_c1", core_reset, 1'b1);
    tick();
    check("core_reset_c2", core_reset, 1'b1);
    tick();
    check("core_reset_fall", core_reset, 1'b0);
  endtask

  task automatic pulse_done(input logic [15:0] y1, input logic [15:0] y2, input logic cls);
    core_y1   = y1;
    core_y2   = y2;
    core_done = 1'b1;
    sb.push_back({cls, y1, y2, 1'b0});
    n_pushed++;
    tick();
    core_done = 1'b0;
    check("valid_latency", class_valid, 1'b1);
  endtask

  task automatic finish_handshake();
    tick();
    check("back_to_fill", {class_valid, sample_ready}, 2'b01);
    check("sb_drained", n_popped, n_pushed);
  endtask

  initial begin
    int cnt;
    repeat (3) tick();
    check("reset_outputs",
          {sample_ready, core_reset, class_out, score1_out, score2_out, timeout_out, class_valid},
          {1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0});
    check("reset_core_x", core_x, 160'h0);
    reset = 1'b0;
    tick();

    // packing + positive compare
    send_window(V1, 0, 10);
    check_launch(V1);
    pulse_done(16'h0800, 16'h0400, 1'b1);
    finish_handshake();

    // gaps in sample_valid + swapped scores
    send_window(V2, 2, 10);
    check_launch(V2);
    pulse_done(16'h0400, 16'h0800, 1'b0);
    finish_handshake();

    // both negative, |a| > |b|
    send_window(V3, 0, 10);
    check_launch(V3);
    repeat (3) tick();
    pulse_done(16'h8800, 16'h8400, 1'b0);
    finish_handshake();

    // +0 vs -0
    send_window(V1, 1, 10);
    check_launch(V1);
    pulse_done(16'h0000, 16'h8000, 1'b1);
    finish_handshake();

    // equal values
    send_window(V2, 0, 10);
    check_launch(V2);
    pulse_done(16'h0400, 16'h0400, 1'b0);
    finish_handshake();

    // timeout: no done at all
    send_window(V3, 0, 10);
    check_launch(V3);
    sb.push_back({1'b0, 16'h0, 16'h0, 1'b1});
    n_pushed++;
    cnt = 0;
    while (!class_valid && cnt < 1100) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, 1024);
    finish_handshake();

    // done in the final RUN cycle beats timeout
    send_window(V1, 0, 10);
    check_launch(V1);
    repeat (1023) tick();
    check("no_early_timeout", class_valid, 1'b0);
    pulse_done(16'h0800, 16'h0400, 1'b1);
    finish_handshake();

    // backpressure; done and samples outside RUN must be ignored
    class_ready = 1'b0;
    send_window(V2, 0, 10);
    check_launch(V2);
    pulse_done(16'h8400, 16'h8800, 1'b1);
    core_done    = 1'b1;
    core_y1      = 16'h0100;
    core_y2      = 16'h0200;
    sample_valid = 1'b1;
    sample_in    = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_stable",
            {class_valid, sample_ready, core_reset, class_out, score1_out, score2_out, timeout_out, core_x},
            {1'b1, 1'b0, 1'b1, 1'b1, 16'h8400, 16'h8800, 1'b0, V2});
    end
    core_done    = 1'b0;
    sample_valid = 1'b0;
    class_ready  = 1'b1;
    finish_handshake();

    // reset mid-window discards the partial window
    send_window(V3, 0, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_state",
          {sample_ready, core_reset, class_valid, core_x},
          {1'b1, 1'b1, 1'b0, 160'h0});
    send_window(V4, 0, 10);
    check_launch(V4);
    pulse_done(16'h0001, 16'h8001, 1'b1);
    finish_handshake();

    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
